// File: rtl/clock_set_ctrl_pkg.sv
// Shared encodings and field limits for the time-setting controller.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_EDIT_HOUR,
    ST_EDIT_MIN,
    ST_EDIT_SEC,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam logic [7:0] SEC_MAX  = 8'd59;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] HOUR_MAX = 8'd23;

  // Modular +/-1 that also pulls an out-of-range value back into 0..vmax.
  function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic [7:0] vmax,
                                           input logic up);
    if (up) return (v >= vmax) ? 8'd0 : v + 8'd1;
    else    return (v == 8'd0 || v > vmax) ? vmax : v - 8'd1;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_key_repeat.sv
// Press edge detect plus hold-to-repeat for one up/down key; emits a
// registered one-cycle step pulse.
module key_repeat #(
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic clk,
  input  logic rset,
  input  logic key,
  input  logic other,
  output logic step
);

  localparam logic [31:0] DLY_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RATE_LAST = 32'(REPEAT_RATE - 1);

  logic        key_q;
  logic        rep;
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (rset) begin
      key_q <= 1'b1;
      rep   <= 1'b0;
      cnt   <= '0;
      step  <= 1'b0;
    end else begin
      key_q <= key;
      step  <= 1'b0;
      // Both keys down (or released) cancels any repeat in progress.
      if (!key || other) begin
        rep <= 1'b0;
        cnt <= '0;
      end else if (!key_q) begin
        step <= 1'b1;
        rep  <= 1'b0;
        cnt  <= '0;
      end else if (cnt == (rep ? RATE_LAST : DLY_LAST)) begin
        step <= 1'b1;
        rep  <= 1'b1;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/up/down time-setting controller: hour -> min -> sec edit sequence,
// stops the timekeeper while editing and issues a one-cycle load on commit.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned BLINK_DIV    = 25000000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter int unsigned TIMEOUT      = 500000000
) (
  input  logic       clk,
  input  logic       rset,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  input  logic [7:0] cur_sec,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_hour,
  output logic       run_en,
  output logic       load,
  output logic [7:0] load_sec,
  output logic [7:0] load_min,
  output logic [7:0] load_hour,
  output logic [1:0] edit_field,
  output logic       blink,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_min,
  output logic [7:0] disp_hour
);

  localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        mode_q, mode_p;
  logic        up_s, dn_s;
  logic [7:0]  edit_sec, edit_min, edit_hour;
  logic [31:0] to_cnt, blink_cnt;
  logic        in_edit, nx_edit, any_evt, timed_out, step_en;

  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .clk(clk), .rset(rset), .key(key_up), .other(key_down), .step(up_s)
  );

  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dn (
    .clk(clk), .rset(rset), .key(key_down), .other(key_up), .step(dn_s)
  );

  always_ff @(posedge clk) begin
    if (rset) begin
      mode_q <= 1'b1;
      mode_p <= 1'b0;
    end else begin
      mode_q <= key_mode;
      mode_p <= key_mode & ~mode_q;
    end
  end

  assign in_edit   = (state == ST_EDIT_HOUR) || (state == ST_EDIT_MIN) || (state == ST_EDIT_SEC);
  assign nx_edit   = (state_nx == ST_EDIT_HOUR) || (state_nx == ST_EDIT_MIN) ||
                     (state_nx == ST_EDIT_SEC);
  assign any_evt   = mode_p | up_s | dn_s;
  assign timed_out = in_edit && !any_evt && (to_cnt == TO_LAST);
  // Mode wins over a coincident step.
  assign step_en   = in_edit && !mode_p && (up_s ^ dn_s);

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:       if (mode_p) state_nx = ST_EDIT_HOUR;
      ST_EDIT_HOUR: if (mode_p) state_nx = ST_EDIT_MIN; else if (timed_out) state_nx = ST_RUN;
      ST_EDIT_MIN:  if (mode_p) state_nx = ST_EDIT_SEC; else if (timed_out) state_nx = ST_RUN;
      ST_EDIT_SEC:  if (mode_p) state_nx = ST_COMMIT;   else if (timed_out) state_nx = ST_RUN;
      default:      state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rset) state <= ST_RUN;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rset) begin
      edit_sec  <= '0;
      edit_min  <= '0;
      edit_hour <= '0;
    end else if (state == ST_RUN && mode_p) begin
      edit_sec  <= cur_sec;
      edit_min  <= cur_min;
      edit_hour <= cur_hour;
    end else if (step_en) begin
      case (state)
        ST_EDIT_HOUR: edit_hour <= wrap_step(edit_hour, HOUR_MAX, up_s);
        ST_EDIT_MIN:  edit_min  <= wrap_step(edit_min, MIN_MAX, up_s);
        default:      edit_sec  <= wrap_step(edit_sec, SEC_MAX, up_s);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rset || !in_edit || any_evt || timed_out) to_cnt <= '0;
    else                                          to_cnt <= to_cnt + 32'd1;
  end

  // Restart the blink phase on every field change so the new field starts visible.
  always_ff @(posedge clk) begin
    if (rset || !nx_edit || state_nx != state) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  always_comb begin
    run_en     = (state == ST_RUN);
    load       = (state == ST_COMMIT);
    load_sec   = edit_sec;
    load_min   = edit_min;
    load_hour  = edit_hour;
    edit_field = FIELD_NONE;
    disp_sec   = edit_sec;
    disp_min   = edit_min;
    disp_hour  = edit_hour;
    case (state)
      ST_RUN: begin
        disp_sec  = cur_sec;
        disp_min  = cur_min;
        disp_hour = cur_hour;
      end
      ST_EDIT_HOUR: edit_field = FIELD_HOUR;
      ST_EDIT_MIN:  edit_field = FIELD_MIN;
      default:      edit_field = FIELD_SEC;
    endcase
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: key-press vector table plus hand
// sequences for commit, auto-repeat, timeout and blink.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rset, key_mode, key_up, key_down;
  logic [7:0] cur_sec, cur_min, cur_hour;
  logic       run_en, load, blink;
  logic [7:0] load_sec, load_min, load_hour;
  logic [1:0] edit_field;
  logic [7:0] disp_sec, disp_min, disp_hour;

  int tests  = 0;
  int failed = 0;
  int load_cnt = 0;

  clock_set_ctrl #(.BLINK_DIV(4), .REPEAT_DELAY(8), .REPEAT_RATE(2), .TIMEOUT(40)) dut (
    .clk(clk), .rset(rset), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .run_en(run_en), .load(load), .load_sec(load_sec), .load_min(load_min),
    .load_hour(load_hour), .edit_field(edit_field), .blink(blink),
    .disp_sec(disp_sec), .disp_min(disp_min), .disp_hour(disp_hour)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rset && load) load_cnt++;

  typedef struct {
    int key;      // 0 mode, 1 up, 2 down
    int ef;
    int hour, min, sec;
    int run;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input int k);
    key_mode = (k == 0);
    key_up   = (k == 1);
    key_down = (k == 2);
    tick();
    key_mode = 1'b0;
    key_up   = 1'b0;
    key_down = 1'b0;
    tick();
  endtask

  function automatic int steps_done(input int k);
    int s[7] = '{1, 9, 11, 13, 15, 17, 19};
    int n = 0;
    for (int i = 0; i < 7; i++) if (s[i] + 1 <= k) n++;
    return n;
  endfunction

  initial begin
    rset = 1'b1; key_mode = 1'b1; key_up = 1'b0; key_down = 1'b0;
    cur_hour = 8'd12; cur_min = 8'd34; cur_sec = 8'd56;

    // Vector table: full edit down to 23:00:55.
    tbl.push_back('{0, 1, 12, 34, 56, 0});
    for (int i = 0; i < 12; i++) tbl.push_back('{1, 1, (13 + i) % 24, 34, 56, 0});
    tbl.push_back('{2, 1, 23, 34, 56, 0});
    tbl.push_back('{0, 2, 23, 34, 56, 0});
    for (int i = 0; i < 26; i++) tbl.push_back('{1, 2, 23, (35 + i) % 60, 56, 0});
    tbl.push_back('{0, 3, 23, 0, 56, 0});
    tbl.push_back('{2, 3, 23, 0, 55, 0});

    // Reset with mode held through release: no edit entry.
    repeat (3) tick();
    rset = 1'b0;
    repeat (3) tick();
    chk("rst_field", edit_field, 0);
    chk("rst_run_en", run_en, 1);
    chk("rst_blink", blink, 0);
    chk("rst_load", load, 0);
    chk("rst_disp_hour", disp_hour, 12);
    chk("rst_disp_sec", disp_sec, 56);
    key_mode = 1'b0;
    repeat (2) tick();
    chk("held_mode_no_entry", edit_field, 0);

    foreach (tbl[i]) begin
      press(tbl[i].key);
      chk($sformatf("vec%0d_field", i), edit_field, tbl[i].ef);
      chk($sformatf("vec%0d_hour", i), disp_hour, tbl[i].hour);
      chk($sformatf("vec%0d_min", i), disp_min, tbl[i].min);
      chk($sformatf("vec%0d_sec", i), disp_sec, tbl[i].sec);
      chk($sformatf("vec%0d_run_en", i), run_en, tbl[i].run);
      chk($sformatf("vec%0d_load", i), load, 0);
    end

    // Commit: exactly one load cycle with the edited time.
    press(0);
    chk("commit_load", load, 1);
    chk("commit_hour", load_hour, 23);
    chk("commit_min", load_min, 0);
    chk("commit_sec", load_sec, 55);
    chk("commit_run_en", run_en, 0);
    chk("commit_field", edit_field, 3);
    tick();
    chk("post_commit_load", load, 0);
    chk("post_commit_run_en", run_en, 1);
    chk("post_commit_field", edit_field, 0);
    chk("post_commit_disp", disp_hour, 12);
    chk("load_pulses_1", load_cnt, 1);

    // Auto-repeat in EDIT_MIN from 0.
    cur_hour = 8'd10; cur_min = 8'd0; cur_sec = 8'd20;
    press(0);
    press(0);
    chk("rep_field", edit_field, 2);
    chk("rep_start", disp_min, 0);
    key_up = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("rep_cyc%0d", k), disp_min, steps_done(k));
    end
    key_up = 1'b0;
    repeat (2) tick();
    chk("rep_final", disp_min, 7);
    key_up = 1'b1; key_down = 1'b1;
    repeat (12) tick();
    chk("both_held", disp_min, 7);
    key_up = 1'b0; key_down = 1'b0;
    repeat (3) tick();
    chk("both_released", disp_min, 7);
    press(0);
    press(0);
    chk("commit2_load", load, 1);
    chk("commit2_val", {16'd0, load_hour, load_min, load_sec}, {16'd0, 8'd10, 8'd7, 8'd20});
    tick();
    chk("load_pulses_2", load_cnt, 2);

    // Timeout abandons the edit.
    press(0);
    press(1);
    chk("to_hour", disp_hour, 11);
    repeat (39) tick();
    chk("to_still_edit", edit_field, 1);
    chk("to_still_stopped", run_en, 0);
    tick();
    chk("to_field", edit_field, 0);
    chk("to_run_en", run_en, 1);
    cur_hour = 8'd5; cur_min = 8'd6; cur_sec = 8'd7;
    #1;
    chk("to_disp_hour", disp_hour, 5);
    chk("to_disp_min", disp_min, 6);
    chk("to_no_load", load_cnt, 2);

    // Mode and up together: mode wins; blink restarts on field entry.
    press(0);
    key_mode = 1'b1; key_up = 1'b1;
    tick();
    key_mode = 1'b0; key_up = 1'b0;
    tick();
    chk("mu_field", edit_field, 2);
    chk("mu_hour", disp_hour, 5);
    chk("mu_min", disp_min, 6);
    chk("mu_blink_entry", blink, 0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("blink_cyc%0d", k), blink, (k / 4) % 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-setting controller for the 24-hour sec/min/hour timekeeper.
- Converts three debounced keys (mode/up/down) into an edit sequence hour -> min -> sec. Holds the timekeeper stopped while editing, then issues a one-cycle parallel load of the edited time.
- Supplies display values and a field-blink strobe to the display driver.

Parameters:
- BLINK_DIV, 25000000, cycles per blink half-period (0.5 s at 50 MHz).
- REPEAT_DELAY, 25000000, cycles an up/down key must be held before auto-repeat starts.
- REPEAT_RATE, 5000000, cycles between auto-repeat steps.
- TIMEOUT, 500000000, idle cycles in edit before edits are abandoned (10 s).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rset  in  1  synchronous, active-high reset.
- key_mode  in  1  debounced level, 1 = pressed.
- key_up  in  1  debounced level, 1 = pressed.
- key_down  in  1  debounced level, 1 = pressed.
- cur_sec  in  8  live seconds from timekeeper, 0..59.
- cur_min  in  8  live minutes, 0..59.
- cur_hour  in  8  live hours, 0..23.
- run_en  out  1  timekeeper count enable.
- load  out  1  one-cycle load strobe.
- load_sec  out  8  value to load.
- load_min  out  8  value to load.
- load_hour  out  8  value to load.
- edit_field  out  2  0 none, 1 hour, 2 min, 3 sec.
- blink  out  1  blink phase; display blanks the edit_field digits when 1.
- disp_sec  out  8  value to display.
- disp_min  out  8  value to display.
- disp_hour  out  8  value to display.

Behaviour:
- Reset (rset=1 at posedge):
  - state RUN; run_en=1; load=0; edit_field=0; blink=0.
  - edit registers=0; all counters=0.
  - Key-history registers =1, so a key held through reset release produces no press.
- Press = rising edge of a key level (current=1, previous=0), registered one cycle. Each press acts in the cycle after the edge.
- States and transitions:
  - RUN -> EDIT_HOUR on mode press. Same edge captures cur_* into edit_sec/min/hour.
  - EDIT_HOUR -> EDIT_MIN -> EDIT_SEC on mode press.
  - EDIT_SEC -> COMMIT on mode press.
  - COMMIT (1 cycle): load=1, load_* = edit registers. Then RUN.
  - Any EDIT state -> RUN on timeout: no load, edits discarded.
- run_en=0 in all EDIT states and COMMIT; run_en=1 in RUN. The timekeeper resumes counting from the loaded value on the cycle after COMMIT.
- load_* hold the edit registers at all times; they are meaningful only while load=1.
- edit_field values: RUN 0, EDIT_HOUR 1, EDIT_MIN 2, EDIT_SEC 3, COMMIT 3.
- Up/down arithmetic on the active field is modular:
  - hour: 23+1 -> 0, 0-1 -> 23.
  - min and sec: 59+1 -> 0, 0-1 -> 59.
  - Values never leave the legal range.
- Auto-repeat (single up or down held alone):
  - First step on the press.
  - Second step after REPEAT_DELAY further cycles held.
  - Then one step every REPEAT_RATE cycles.
  - Release clears the repeat counter.
- Simultaneous events:
  - up and down both high: no step; repeat counter cleared.
  - mode press together with up/down: mode wins, no step in the old or new field.
  - up/down in RUN: ignored.
  - mode during COMMIT: ignored.
- Timeout counter: cleared on any press or repeat step and on entry to EDIT_HOUR. Increments in EDIT states; reaching TIMEOUT-1 forces RUN.
- Blink: free-running counter toggles blink every BLINK_DIV cycles while in EDIT states. blink is forced 0 and the counter cleared in RUN/COMMIT, so a new field always starts visible (blink=0).
- Display: RUN -> disp_* = cur_* (combinational pass-through). EDIT/COMMIT -> disp_* = edit registers.
- Counter widths: 32 bits, compare with equality to parameter-1.

Decomposition:
- Shared package clock_pkg:
  - state encoding (RUN, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT);
  - edit_field codes;
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
- One sub-module key_repeat, instantiated twice (up, down): edge detect plus delay/rate auto-repeat, output one-cycle step pulse. Mode key uses a plain edge detect inside the top module.

Test Plan (sim parameters BLINK_DIV=4, REPEAT_DELAY=8, REPEAT_RATE=2, TIMEOUT=40):
- Reset with key_mode held high, release rset -> state RUN, run_en=1, no edit entry until key_mode drops and rises again.
- cur=12:34:56, mode press -> edit_field=1, disp=12:34:56, run_en=0. Up press x12 -> edit_hour 0. Down press -> 23.
- Full edit: hour 23, mode, min 59 with up -> 0, mode, sec down from 56 -> 55, mode -> exactly one cycle load=1 with load=23:00:55, then run_en=1, edit_field=0.
- Hold key_up 20 cycles in EDIT_MIN from 0 -> steps at cycles 1, 9, 11, 13, 15, 17, 19 (min=7); up+down held together -> no change.
- Enter edit, change hour, idle 40 cycles -> return to RUN, load never asserted, disp follows cur_*.
- mode and up rising on the same cycle in EDIT_HOUR -> edit_field=2, edit_hour and edit_min unchanged; blink=0 on field entry, toggling every 4 cycles after.
